// File: rtl/test_pattern_sequencer_if.sv
// Video timing in / coloured video out bundle for the test pattern sequencer.
// master drives timing and consumes video; slave is the sequencer.
interface test_pattern_sequencer_if #(
   parameter int VIDEO_WIDTH = 3
);
   logic [9:0]             i_hpos;
   logic [9:0]             i_vpos;
   logic                   i_visible;
   logic                   i_hsync;
   logic                   i_vsync;
   logic [VIDEO_WIDTH-1:0] o_red_video;
   logic [VIDEO_WIDTH-1:0] o_grn_video;
   logic [VIDEO_WIDTH-1:0] o_blu_video;
   logic                   o_hsync;
   logic                   o_vsync;
   logic                   o_visible;

   modport master (
      output i_hpos, i_vpos, i_visible, i_hsync, i_vsync,
      input  o_red_video, o_grn_video, o_blu_video,
      input  o_hsync, o_vsync, o_visible
   );

   modport slave (
      input  i_hpos, i_vpos, i_visible, i_hsync, i_vsync,
      output o_red_video, o_grn_video, o_blu_video,
      output o_hsync, o_vsync, o_visible
   );
endinterface

// File: rtl/test_pattern_sequencer.sv
// Ten-pattern video test generator, 2-stage pipeline, frame-locked auto cycling.
// Define TEST_PATTERN_CROSSHAIR_EN to overlay a centre crosshair.
module test_pattern_sequencer #(
   parameter int VIDEO_WIDTH  = 3,
   parameter int H_VISIBLE    = 640,
   parameter int V_VISIBLE    = 480,
   parameter int NUM_BARS     = 8,
   parameter int BORDER_WIDTH = 8,
   parameter int DWELL_FRAMES = 120,
   parameter int SCROLL_STEP  = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [3:0]              i_pattern,
   input  logic                    i_auto,
   input  logic                    i_frame_strobe,
   output logic [3:0]              o_active_pattern,
   test_pattern_sequencer_if.slave vid
);

   localparam int VW   = VIDEO_WIDTH;
   localparam int RW   = VIDEO_WIDTH + 10;
   localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
   localparam logic [7:0]      STEP       = 8'(SCROLL_STEP);
   localparam logic [VW-1:0]   FULL       = '1;
   localparam logic [9:0]      BAR_W      = 10'(H_VISIBLE / NUM_BARS);
   localparam logic [9:0]      NBARS      = 10'(NUM_BARS);
   localparam logic [9:0]      BW         = 10'(BORDER_WIDTH);
   localparam logic [9:0]      H_HI       = 10'(H_VISIBLE - BORDER_WIDTH);
   localparam logic [9:0]      V_HI       = 10'(V_VISIBLE - BORDER_WIDTH);
   localparam logic [RW-1:0]   H_DIV      = RW'(H_VISIBLE);
   localparam logic [RW-1:0]   RAMP_MAX   = RW'((1 << VIDEO_WIDTH) - 1);

   typedef enum logic {ST_MANUAL, ST_AUTO} state_t;

   state_t          r_state, w_state_nx;
   logic [3:0]      r_active, w_active_nx;
   logic [DW_W-1:0] r_dwell, w_dwell_nx;
   logic [7:0]      r_offset;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_MANUAL;
         r_active <= '0;
         r_dwell  <= '0;
         r_offset <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_active <= w_active_nx;
         r_dwell  <= w_dwell_nx;
         if (i_frame_strobe)
            r_offset <= r_offset + STEP;
      end
   end

   // Pattern index only moves on the frame strobe so a frame is never torn.
   always_comb begin
      w_state_nx  = r_state;
      w_active_nx = r_active;
      w_dwell_nx  = r_dwell;
      if (i_frame_strobe) begin
         case (r_state)
            ST_MANUAL: begin
               w_active_nx = i_pattern;
               if (i_auto) begin
                  w_state_nx = ST_AUTO;
                  w_dwell_nx = '0;
                  if (i_pattern == 4'd0)
                     w_active_nx = 4'd1;
               end
            end
            ST_AUTO: begin
               if (!i_auto) begin
                  w_state_nx  = ST_MANUAL;
                  w_active_nx = i_pattern;
               end else if (r_dwell == DWELL_LAST) begin
                  w_dwell_nx  = '0;
                  w_active_nx = (r_active >= 4'd9) ? 4'd1 : r_active + 4'd1;
               end else begin
                  w_dwell_nx = r_dwell + 1'b1;
               end
            end
            default: w_state_nx = ST_MANUAL;
         endcase
      end
   end

   logic [9:0]    w_bar_raw;
   logic [2:0]    w_bar;
   logic          w_border;
   logic [10:0]   w_p;
   logic [VW+2:0] w_iwide;
   logic [RW-1:0] w_ramp_full;
   logic [VW-1:0] w_ramp;
   logic          w_unused;

   always_comb begin
      w_bar_raw   = vid.i_hpos / BAR_W;
      w_bar       = (w_bar_raw >= NBARS) ? 3'd0 : w_bar_raw[2:0];
      w_border    = (vid.i_hpos < BW) || (vid.i_hpos >= H_HI) ||
                    (vid.i_vpos < BW) || (vid.i_vpos >= V_HI);
      w_p         = {1'b0, vid.i_vpos} + {3'b000, r_offset};
      w_iwide     = {w_p[3:1], {VW{1'b0}}};
      w_ramp_full = {vid.i_hpos, {VW{1'b0}}} / H_DIV;
      w_ramp      = (w_ramp_full > RAMP_MAX) ? FULL : w_ramp_full[VW-1:0];
   end

   assign w_unused = ^{w_p[10:7], w_p[0], w_iwide[2:0]};

   logic          r1_visible, r1_hsync, r1_vsync;
   logic [2:0]    r1_bar;
   logic          r1_border;
   logic [2:0]    r1_plaid;
   logic [VW-1:0] r1_scr_int;
   logic [2:0]    r1_scr_sel;
   logic          r1_check;
   logic [VW-1:0] r1_ramp;
`ifdef TEST_PATTERN_CROSSHAIR_EN
   logic [9:0]    r1_hpos, r1_vpos;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r1_visible <= 1'b0;
         r1_hsync   <= 1'b1;
         r1_vsync   <= 1'b1;
         r1_bar     <= '0;
         r1_border  <= 1'b0;
         r1_plaid   <= '0;
         r1_scr_int <= '0;
         r1_scr_sel <= '0;
         r1_check   <= 1'b0;
         r1_ramp    <= '0;
`ifdef TEST_PATTERN_CROSSHAIR_EN
         r1_hpos    <= '0;
         r1_vpos    <= '0;
`endif
      end else begin
         r1_visible <= vid.i_visible;
         r1_hsync   <= vid.i_hsync;
         r1_vsync   <= vid.i_vsync;
         r1_bar     <= w_bar;
         r1_border  <= w_border;
         r1_plaid   <= {(vid.i_hpos[2:0] == 3'd0) || (vid.i_vpos[2:0] == 3'd0),
                        vid.i_vpos[4], vid.i_hpos[4]};
         r1_scr_int <= w_iwide[VW+2:3];
         r1_scr_sel <= w_p[6:4];
         r1_check   <= vid.i_hpos[5] ^ vid.i_vpos[5];
         r1_ramp    <= w_ramp;
`ifdef TEST_PATTERN_CROSSHAIR_EN
         r1_hpos    <= vid.i_hpos;
         r1_vpos    <= vid.i_vpos;
`endif
      end
   end

   logic [VW-1:0] w_red, w_grn, w_blu;

   always_comb begin
      w_red = '0;
      w_grn = '0;
      w_blu = '0;
      case (r_active)
         4'd1: w_red = FULL;
         4'd2: w_grn = FULL;
         4'd3: w_blu = FULL;
         4'd4: begin
            w_red = {VW{~r1_bar[1]}};
            w_grn = {VW{~r1_bar[2]}};
            w_blu = {VW{~r1_bar[0]}};
         end
         4'd5: begin
            w_red = {VW{r1_border}};
            w_grn = {VW{r1_border}};
            w_blu = {VW{r1_border}};
         end
         4'd6: begin
            w_red = {VW{r1_plaid[2]}};
            w_grn = {VW{r1_plaid[1]}};
            w_blu = {VW{r1_plaid[0]}};
         end
         4'd7: begin
            w_red = r1_scr_sel[1] ? r1_scr_int : '0;
            w_grn = r1_scr_sel[2] ? r1_scr_int : '0;
            w_blu = r1_scr_sel[0] ? r1_scr_int : '0;
         end
         4'd8: begin
            w_red = {VW{r1_check}};
            w_grn = {VW{r1_check}};
            w_blu = {VW{r1_check}};
         end
         4'd9: begin
            w_red = r1_ramp;
            w_grn = r1_ramp;
            w_blu = r1_ramp;
         end
         default: ;
      endcase
`ifdef TEST_PATTERN_CROSSHAIR_EN
      if ((r_active != 4'd0) &&
          ((r1_hpos == 10'(H_VISIBLE / 2)) || (r1_vpos == 10'(V_VISIBLE / 2)))) begin
         w_red = FULL;
         w_grn = FULL;
         w_blu = FULL;
      end
`endif
      if (!r1_visible) begin
         w_red = '0;
         w_grn = '0;
         w_blu = '0;
      end
   end

   logic [VW-1:0] r2_red, r2_grn, r2_blu;
   logic          r2_hsync, r2_vsync, r2_visible;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r2_red     <= '0;
         r2_grn     <= '0;
         r2_blu     <= '0;
         r2_hsync   <= 1'b1;
         r2_vsync   <= 1'b1;
         r2_visible <= 1'b0;
      end else begin
         r2_red     <= w_red;
         r2_grn     <= w_grn;
         r2_blu     <= w_blu;
         r2_hsync   <= r1_hsync;
         r2_vsync   <= r1_vsync;
         r2_visible <= r1_visible;
      end
   end

   assign vid.o_red_video  = r2_red;
   assign vid.o_grn_video  = r2_grn;
   assign vid.o_blu_video  = r2_blu;
   assign vid.o_hsync      = r2_hsync;
   assign vid.o_vsync      = r2_vsync;
   assign vid.o_visible    = r2_visible;
   assign o_active_pattern = r_active;

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Directed scoreboard bench for test_pattern_sequencer (VIDEO_WIDTH=3,
// DWELL_FRAMES=2); expected pixels are queued at drive time, popped 2 cycles on.
module tb_test_pattern_sequencer;
   localparam int VW    = 3;
   localparam int DWELL = 2;
   localparam int STEP  = 2;
   localparam int F     = 7;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] pat;
   logic       autom;
   logic       stb;
   logic [3:0] act;

   always #5 clk = ~clk;

   test_pattern_sequencer_if #(.VIDEO_WIDTH(VW)) vif();

   test_pattern_sequencer #(
      .VIDEO_WIDTH(VW), .H_VISIBLE(640), .V_VISIBLE(480), .NUM_BARS(8),
      .BORDER_WIDTH(8), .DWELL_FRAMES(DWELL), .SCROLL_STEP(STEP)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_pattern(pat), .i_auto(autom),
      .i_frame_strobe(stb), .o_active_pattern(act), .vid(vif)
   );

   typedef struct {
      int r, g, b;
      logic hs, vs, vis, ck;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   bit m_auto;
   int m_active, m_dwell, m_off;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void colour(input int pn, input int h, input int v,
                                  input bit vis, input int off,
                                  output int r, output int g, output int b);
      int bar, p, i;
      r = 0; g = 0; b = 0;
      if (!vis) return;
      case (pn)
         1: r = F;
         2: g = F;
         3: b = F;
         4: begin
            bar = h / 80;
            if (bar >= 8) bar = 0;
            r = ((bar & 2) != 0) ? 0 : F;
            g = ((bar & 4) != 0) ? 0 : F;
            b = ((bar & 1) != 0) ? 0 : F;
         end
         5: if (h < 8 || h >= 632 || v < 8 || v >= 472) begin
            r = F; g = F; b = F;
         end
         6: begin
            r = ((h % 8) == 0 || (v % 8) == 0) ? F : 0;
            g = ((v & 16) != 0) ? F : 0;
            b = ((h & 16) != 0) ? F : 0;
         end
         7: begin
            p = v + off;
            i = (p >> 1) & 7;
            r = ((p & 32) != 0) ? i : 0;
            g = ((p & 64) != 0) ? i : 0;
            b = ((p & 16) != 0) ? i : 0;
         end
         8: if ((((h >> 5) ^ (v >> 5)) & 1) != 0) begin
            r = F; g = F; b = F;
         end
         9: begin
            i = h * 8 / 640;
            if (i > 7) i = 7;
            r = i; g = i; b = i;
         end
         default: ;
      endcase
   endfunction

   function automatic void model_strobe();
      if (!m_auto) begin
         m_active = pat;
         if (autom) begin
            m_auto   = 1'b1;
            m_active = (pat == 0) ? 1 : int'(pat);
            m_dwell  = 0;
         end
      end else if (!autom) begin
         m_auto   = 1'b0;
         m_active = pat;
      end else if (m_dwell == DWELL - 1) begin
         m_dwell  = 0;
         m_active = (m_active >= 9) ? 1 : m_active + 1;
      end else begin
         m_dwell++;
      end
      m_off = (m_off + STEP) % 256;
   endfunction

   task automatic step(input int h, input int v, input logic vis,
                       input logic hs, input logic vs,
                       input logic s, input logic ck);
      exp_t e;
      int off_old;
      @(negedge clk);
      if (sb.size() == 2) begin
         e = sb.pop_front();
         if (e.ck) begin
            chk("red", 32'(vif.o_red_video), e.r);
            chk("grn", 32'(vif.o_grn_video), e.g);
            chk("blu", 32'(vif.o_blu_video), e.b);
            chk("hsync", 32'(vif.o_hsync), 32'(e.hs));
            chk("vsync", 32'(vif.o_vsync), 32'(e.vs));
            chk("visible", 32'(vif.o_visible), 32'(e.vis));
         end
      end
      chk("active", 32'(act), m_active);
      vif.i_hpos    = 10'(h);
      vif.i_vpos    = 10'(v);
      vif.i_visible = vis;
      vif.i_hsync   = hs;
      vif.i_vsync   = vs;
      stb           = s;
      off_old       = m_off;
      if (s) model_strobe();
      colour(m_active, h, v, vis, off_old, e.r, e.g, e.b);
      e.hs  = hs;
      e.vs  = vs;
      e.vis = vis;
      e.ck  = ck;
      sb.push_back(e);
   endtask

   task automatic px(input int h, input int v, input logic vis);
      step(h, v, vis, 1'b1, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic sstb(input logic [3:0] p, input logic a);
      pat   = p;
      autom = a;
      step(0, 480, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      stb           = 1'b0;
      vif.i_hsync   = 1'b0;
      vif.i_vsync   = 1'b0;
      vif.i_visible = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_red", 32'(vif.o_red_video), 0);
      chk("rst_grn", 32'(vif.o_grn_video), 0);
      chk("rst_blu", 32'(vif.o_blu_video), 0);
      chk("rst_hsync", 32'(vif.o_hsync), 1);
      chk("rst_vsync", 32'(vif.o_vsync), 1);
      chk("rst_visible", 32'(vif.o_visible), 0);
      chk("rst_active", 32'(act), 0);
      rst = 1'b0;
      sb.delete();
      m_auto = 1'b0; m_active = 0; m_dwell = 0; m_off = 0;
   endtask

   initial begin
      rst = 1'b1; pat = 4'd0; autom = 1'b0; stb = 1'b0;
      vif.i_hpos = '0; vif.i_vpos = '0; vif.i_visible = 1'b0;
      vif.i_hsync = 1'b1; vif.i_vsync = 1'b1;
      do_reset();

      sstb(4'd1, 1'b0);
      step(100, 100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(101, 100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(102, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(103, 100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      pat = 4'd2;
      px(200, 200, 1'b1);
      px(201, 200, 1'b1);
      sstb(4'd2, 1'b0);
      px(300, 10, 1'b1);
      px(300, 10, 1'b0);

      sstb(4'd4, 1'b0);
      for (int k = 0; k < 8; k++) px(k * 80 + 5, 50, 1'b1);
      px(79, 50, 1'b1);
      px(639, 50, 1'b1);

      sstb(4'd5, 1'b0);
      px(0, 100, 1'b0);
      px(639, 100, 1'b1);
      px(320, 240, 1'b1);
      px(7, 100, 1'b1);
      px(8, 100, 1'b1);
      px(320, 471, 1'b1);
      px(320, 472, 1'b1);
      px(320, 7, 1'b1);

      sstb(4'd6, 1'b0);
      px(0, 3, 1'b1);
      px(3, 8, 1'b1);
      px(19, 17, 1'b1);
      px(21, 5, 1'b1);

      sstb(4'd7, 1'b0);
      px(10, 62, 1'b1);
      px(10, 0, 1'b1);
      px(10, 17, 1'b1);
      px(10, 100, 1'b1);
      px(10, 479, 1'b1);

      sstb(4'd8, 1'b0);
      px(10, 10, 1'b1);
      px(40, 10, 1'b1);
      px(40, 40, 1'b1);

      sstb(4'd9, 1'b0);
      px(0, 5, 1'b1);
      px(79, 5, 1'b1);
      px(80, 5, 1'b1);
      px(400, 5, 1'b1);
      px(639, 5, 1'b1);
      px(700, 5, 1'b1);

      sstb(4'd10, 1'b0);
      px(100, 100, 1'b1);
      sstb(4'd15, 1'b0);
      px(100, 100, 1'b1);
      sstb(4'd0, 1'b0);
      px(100, 100, 1'b1);

      for (int n = 0; n < 19; n++) begin
         sstb(4'd0, 1'b1);
         @(posedge clk);
         #1;
         chk("auto_seq", 32'(act), (n / 2) % 9 + 1);
         px(50, 60, 1'b1);
         autom = 1'b0;
         pat   = 4'd3;
         px(51, 60, 1'b1);
      end

      sstb(4'd8, 1'b0);
      px(40, 10, 1'b1);
      sstb(4'd5, 1'b1);
      px(0, 0, 1'b1);
      sstb(4'd5, 1'b1);
      px(320, 240, 1'b1);
      px(3, 240, 1'b1);

      do_reset();
      px(5, 5, 1'b1);
      pat   = 4'd7;
      autom = 1'b0;
      step(10, 62, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      px(10, 62, 1'b1);
      sstb(4'd0, 1'b1);
      px(200, 200, 1'b1);
      repeat (3) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/test_pattern_sequencer.md
Name: test_pattern_sequencer

Overview:
- Parametrised successor to the fixed 3-bit VGA test pattern generator.
- Generates 10 test patterns at any colour depth, with a registered 2-stage pipeline.
- Delays sync and visible signals so they stay aligned with the video output.
- Adds an auto-cycle mode that steps through patterns on frame boundaries, and only changes pattern between frames (no tearing).
- Sits between the VGA sync/position generator and the video output/porch stage.

Parameters:
- VIDEO_WIDTH, 3, bits per colour channel (≥1).
- H_VISIBLE, 640, visible pixels per line.
- V_VISIBLE, 480, visible lines per frame.
- NUM_BARS, 8, vertical colour bars in pattern 4 (1..8); bar width = H_VISIBLE/NUM_BARS.
- BORDER_WIDTH, 8, border thickness in pixels for pattern 5.
- DWELL_FRAMES, 120, frames each pattern is shown in auto mode (≥1).
- SCROLL_STEP, 2, scroll offset increment per frame for pattern 7.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  synchronous reset, active-high.
- i_pattern  in  4  requested pattern in manual mode.
- i_auto  in  1  1 = auto-cycle mode, 0 = manual mode.
- i_hpos  in  10  pixel column.
- i_vpos  in  10  pixel row.
- i_visible  in  1  pixel is in the visible area.
- i_hsync  in  1  horizontal sync (active-low), passed through.
- i_vsync  in  1  vertical sync (active-low), passed through.
- i_frame_strobe  in  1  one-cycle pulse at start of vertical blanking.
- o_red_video  out  VIDEO_WIDTH  red channel.
- o_grn_video  out  VIDEO_WIDTH  green channel.
- o_blu_video  out  VIDEO_WIDTH  blue channel.
- o_hsync  out  1  i_hsync delayed by 2 cycles.
- o_vsync  out  1  i_vsync delayed by 2 cycles.
- o_visible  out  1  i_visible delayed by 2 cycles.
- o_active_pattern  out  4  pattern currently displayed.

Behaviour:

Reset (i_rst=1 at a clock edge):
- All colour outputs = 0; o_visible = 0.
- o_hsync = o_vsync = 1; all pipeline sync stages also = 1.
- o_active_pattern = 0; FSM = MANUAL; dwell counter = 0; scroll offset = 0.
- Reset in mid-frame takes effect at the next edge; pipeline contents are discarded.

Pipeline:
- Stage 1 registers hpos, vpos, visible, syncs and per-pattern intermediate terms.
- Stage 2 muxes on the active pattern and registers the outputs.
- Latency from inputs to all outputs is exactly 2 cycles.

Pattern index latch and FSM:
- Active pattern updates only on cycles where i_frame_strobe=1.
- MANUAL:
  - On strobe: active ← i_pattern.
  - If i_auto=1 on that same strobe: go to AUTO; active ← (i_pattern==0 ? 1 : i_pattern); dwell ← 0.
- AUTO:
  - On strobe with i_auto=0: go to MANUAL; active ← i_pattern.
  - Otherwise, if dwell == DWELL_FRAMES-1: dwell ← 0; active advances 1→2→…→9→1 (never 0).
  - Otherwise: dwell ← dwell+1.
- i_auto and i_pattern changes between strobes have no effect.

Scroll offset:
- 8-bit; on each strobe, offset += SCROLL_STEP, wrapping mod 256.

Patterns (F = all ones, VIDEO_WIDTH bits):
- 0: black.
- 1: red=F.
- 2: green=F.
- 3: blue=F.
- 4: bar b = hpos/barwidth; b ≥ NUM_BARS → b = 0.
  - red = F if ~b[1], green = F if ~b[2], blue = F if ~b[0].
- 5: white F on every channel within BORDER_WIDTH of any visible edge; black inside.
- 6: plaid.
  - red = F if hpos[2:0]==0 or vpos[2:0]==0.
  - green = F if vpos[4]; blue = F if hpos[4].
- 7: scroll. p = vpos + offset (11 bit); I = p[3:1] left-justified to VIDEO_WIDTH (truncated if VIDEO_WIDTH<3).
  - red = I if p[5], green = I if p[6], blue = I if p[4].
- 8: checkerboard; all channels F when hpos[5]^vpos[5], else 0.
- 9: horizontal grey ramp; all channels = top VIDEO_WIDTH bits of (hpos*2^VIDEO_WIDTH/H_VISIBLE), saturating at F.
- 10–15: black.

Blanking:
- Stage-1 visible = 0 forces all three colour outputs to 0, regardless of pattern.

Optional Feature:
- Macro: TEST_PATTERN_CROSSHAIR_EN.
- Defined: when active pattern ≠ 0 and pixel is visible, pixels with hpos == H_VISIBLE/2 or vpos == V_VISIBLE/2 output F on all channels, overriding the pattern. Applied in stage 2; latency unchanged.
- Undefined: no overlay; no extra logic.

Test Plan:
- Reset, manual, i_pattern=1, pulse strobe → o_active_pattern=1; visible pixel gives red=7, green=blue=0 two cycles later; o_hsync tracks i_hsync with a 2-cycle delay.
- Change i_pattern 1→2 in mid-frame → colour unchanged until next strobe, then green=7.
- i_auto=1, DWELL_FRAMES=2, i_pattern=0 → patterns 1,1,2,2,…,9,9,1 on successive strobes; 0 is never shown.
- VIDEO_WIDTH=4, pattern 7, offset 0, vpos=0x3E → p[5]=1, I=3'b111→4'b1110; red=14, green=0, blue=14.
- Pattern 5 with i_visible=0 at hpos=0 → all channels 0; with i_visible=1 at hpos=639 → all 7; at hpos=320, vpos=240 → 0.
- i_rst asserted mid-frame in AUTO → next cycle all outputs 0, syncs 1, o_active_pattern=0, FSM MANUAL.
